// File: rtl/regfile_pkg.sv
// Register-file geometry shared by the writeback arbiter, the register file and decode.
package regfile_pkg;
    localparam int AW       = 5;
    localparam int WIDTH    = 64;
    localparam int ZERO_REG = 31;
    localparam int NUM_REGS = 32;
    localparam int NUM_REQ  = 4;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr, found by
// scanning a doubled copy of the valid vector so the wrap-around needs no special case.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grantIdx,
    output logic               anyGrant
);
    localparam int DW = $clog2(2 * NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [DW-1:0]        pos_s;

    assign dbl_s = {valid, valid};

    // Priority scan from ptr over the doubled vector; the first hit wins.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        pos_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_s = DW'(ptr) + DW'(k);
            if (enable && !anyGrant && dbl_s[pos_s]) begin
                anyGrant = 1'b1;
                grantIdx = (pos_s >= DW'(NUM_REQ)) ? IW'(pos_s - DW'(NUM_REQ)) : IW'(pos_s);
            end else begin
                anyGrant = anyGrant;
            end
        end
        grant[grantIdx] = anyGrant;
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file's single write port among NUM_REQ writeback sources.
// Round-robin grant, one write per cycle, writes to the zero register are counted and dropped.
module regfile_wr_arbiter #(
    parameter int NUM_REQ  = regfile_pkg::NUM_REQ,
    parameter int WIDTH    = regfile_pkg::WIDTH,
    parameter int AW       = regfile_pkg::AW,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Hold,
    input  logic [NUM_REQ-1:0]         ReqValid,
    output logic [NUM_REQ-1:0]         ReqReady,
    input  logic [NUM_REQ*AW-1:0]      ReqRW,
    input  logic [NUM_REQ*WIDTH-1:0]   ReqBusW,
    output logic                       RegWr,
    output logic [AW-1:0]              RW,
    output logic [WIDTH-1:0]           BusW,
    output logic [$clog2(NUM_REQ)-1:0] GrantId,
    output logic [15:0]                DropCount
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]    ptr_r;
    logic [IW-1:0]    nextPtr_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [IW-1:0]    grantIdx_s;
    logic             anyGrant_s;
    logic             enable_s;
    logic [AW-1:0]    selRW_s;
    logic [WIDTH-1:0] selBusW_s;
    logic             isZero_s;

    logic             regWr_r;
    logic [AW-1:0]    rw_r;
    logic [WIDTH-1:0] busW_r;
    logic [IW-1:0]    grantId_r;
    logic [15:0]      dropCount_r;

    // Reset also blocks grants so nothing is accepted while it is asserted.
    assign enable_s = !Hold && !Reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .valid    (ReqValid),
        .ptr      (ptr_r),
        .enable   (enable_s),
        .grant    (grant_s),
        .grantIdx (grantIdx_s),
        .anyGrant (anyGrant_s)
    );

    assign ReqReady  = grant_s;
    assign selRW_s   = ReqRW[int'(grantIdx_s)*AW +: AW];
    assign selBusW_s = ReqBusW[int'(grantIdx_s)*WIDTH +: WIDTH];
    assign isZero_s  = (selRW_s == AW'(ZERO_REG));
    assign nextPtr_s = (grantIdx_s == IW'(NUM_REQ - 1)) ? '0 : grantIdx_s + IW'(1);

    // Capture the granted write, advance the round-robin pointer, count dropped zero-reg writes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr_r       <= '0;
            regWr_r     <= 1'b0;
            rw_r        <= '0;
            busW_r      <= '0;
            grantId_r   <= '0;
            dropCount_r <= 16'd0;
        end else if (anyGrant_s) begin
            ptr_r     <= nextPtr_s;
            rw_r      <= selRW_s;
            busW_r    <= selBusW_s;
            grantId_r <= grantIdx_s;
            regWr_r   <= !isZero_s;
            if (isZero_s && (dropCount_r != 16'hFFFF)) begin
                dropCount_r <= dropCount_r + 16'd1;
            end
        end else begin
            regWr_r <= 1'b0;
        end
    end

    assign RegWr     = regWr_r;
    assign RW        = rw_r;
    assign BusW      = busW_r;
    assign GrantId   = grantId_r;
    assign DropCount = dropCount_r;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a behavioural register file committing on negedge.
module tb_regfile_wr_arbiter;
    localparam int NR = 4;
    localparam int AW = 5;
    localparam int W  = 64;
    localparam int IW = 2;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Hold = 1'b0;
    logic [NR-1:0]     ReqValid = '0;
    logic [NR-1:0]     ReqReady;
    logic [NR*AW-1:0]  ReqRW = '0;
    logic [NR*W-1:0]   ReqBusW = '0;
    logic              RegWr;
    logic [AW-1:0]     RW;
    logic [W-1:0]      BusW;
    logic [IW-1:0]     GrantId;
    logic [15:0]       DropCount;

    int cmpCount = 0;
    int errCount = 0;
    logic [W-1:0] rf [32];

    regfile_wr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .AW(AW), .ZERO_REG(31)) dut (
        .Clk(Clk), .Reset(Reset), .Hold(Hold), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqRW(ReqRW), .ReqBusW(ReqBusW), .RegWr(RegWr), .RW(RW), .BusW(BusW),
        .GrantId(GrantId), .DropCount(DropCount)
    );

    always #5 Clk = ~Clk;

    // Register file model: commits on the falling edge in the middle of the output cycle.
    always @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int j = 0; j < 32; j++) rf[j] <= '0;
        end else if (RegWr) begin
            rf[RW] <= BusW;
        end
    end

    // A pending request must stay valid with stable data until it is accepted.
    for (genvar gi = 0; gi < NR; gi++) begin : g_proto
        assert property (@(posedge Clk) disable iff (Reset)
            (ReqValid[gi] && !ReqReady[gi]) |=>
            (ReqValid[gi] && $stable(ReqRW[gi*AW +: AW]) && $stable(ReqBusW[gi*W +: W])))
            else $error("requester %0d withdrew or changed a pending request", gi);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic [AW-1:0] rw, input logic [W-1:0] d);
        ReqRW[i*AW +: AW] = rw;
        ReqBusW[i*W +: W] = d;
    endtask

    task automatic do_reset();
        ReqValid = '0;
        Hold = 1'b0;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        ReqValid = '0;
        Reset = 1'b1;
        tick();
        cmpCount++; if (RegWr !== 1'b0) begin errCount++; $display("FAIL rst_regwr: got %b want 0", RegWr); end
        cmpCount++; if (RW !== 5'd0) begin errCount++; $display("FAIL rst_rw: got %0d want 0", RW); end
        cmpCount++; if (BusW !== 64'd0) begin errCount++; $display("FAIL rst_busw: got %h want 0", BusW); end
        cmpCount++; if (GrantId !== 2'd0) begin errCount++; $display("FAIL rst_grantid: got %0d want 0", GrantId); end
        cmpCount++; if (DropCount !== 16'd0) begin errCount++; $display("FAIL rst_dropcount: got %0d want 0", DropCount); end
        for (int i = 0; i < NR; i++) setReq(i, AW'(i + 1), 64'hA000_0000 + 64'(i));
        ReqValid = 4'b1111;
        #1;
        cmpCount++; if (ReqReady !== 4'b0000) begin errCount++; $display("FAIL rst_ready_in_reset: got %b want 0000", ReqReady); end
        Reset = 1'b0;
        #1;
        cmpCount++; if (ReqReady !== 4'b0001) begin errCount++; $display("FAIL rst_ready_release: got %b want 0001", ReqReady); end
        tick();
        tick();
        cmpCount++; if (GrantId !== 2'd1) begin errCount++; $display("FAIL rst_pre_grant: got %0d want 1", GrantId); end
        #2 Reset = 1'b1;
        #1;
        cmpCount++; if (RegWr !== 1'b0) begin errCount++; $display("FAIL rst_mid_regwr: got %b want 0", RegWr); end
        cmpCount++; if (RW !== 5'd0) begin errCount++; $display("FAIL rst_mid_rw: got %0d want 0", RW); end
        cmpCount++; if (BusW !== 64'd0) begin errCount++; $display("FAIL rst_mid_busw: got %h want 0", BusW); end
        cmpCount++; if (GrantId !== 2'd0) begin errCount++; $display("FAIL rst_mid_grantid: got %0d want 0", GrantId); end
        cmpCount++; if (ReqReady !== 4'b0000) begin errCount++; $display("FAIL rst_mid_ready: got %b want 0000", ReqReady); end
        #1 Reset = 1'b0;
        #1;
        cmpCount++; if (ReqReady !== 4'b0001) begin errCount++; $display("FAIL rst_ptr_zero: got %b want 0001", ReqReady); end
        tick();
        cmpCount++; if (GrantId !== 2'd0) begin errCount++; $display("FAIL rst_first_grant: got %0d want 0", GrantId); end
        cmpCount++; if (RegWr !== 1'b1 || RW !== 5'd1) begin errCount++; $display("FAIL rst_first_write: got regwr=%b rw=%0d want regwr=1 rw=1", RegWr, RW); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NR; i++) setReq(i, AW'(i + 1), 64'hA000_0000 + 64'(i));
        ReqValid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            int e;
            e = k % 4;
            #1;
            cmpCount++; if (ReqReady !== (4'b0001 << e)) begin errCount++; $display("FAIL rr_ready[%0d]: got %b want %b", k, ReqReady, 4'b0001 << e); end
            tick();
            cmpCount++; if (GrantId !== IW'(e)) begin errCount++; $display("FAIL rr_grantid[%0d]: got %0d want %0d", k, GrantId, e); end
            cmpCount++; if (RegWr !== 1'b1) begin errCount++; $display("FAIL rr_regwr[%0d]: got %b want 1", k, RegWr); end
            cmpCount++; if (RW !== AW'(e + 1)) begin errCount++; $display("FAIL rr_rw[%0d]: got %0d want %0d", k, RW, e + 1); end
            cmpCount++; if (BusW !== 64'hA000_0000 + 64'(e)) begin errCount++; $display("FAIL rr_busw[%0d]: got %h want %h", k, BusW, 64'hA000_0000 + 64'(e)); end
        end
    endtask

    task automatic test_sparse();
        do_reset();
        setReq(2, 5'd5, 64'hDEAD_BEEF);
        ReqValid = 4'b0100;
        #1;
        cmpCount++; if (ReqReady !== 4'b0100) begin errCount++; $display("FAIL sp_ready2: got %b want 0100", ReqReady); end
        tick();
        cmpCount++; if (RegWr !== 1'b1 || RW !== 5'd5) begin errCount++; $display("FAIL sp_write2: got regwr=%b rw=%0d want regwr=1 rw=5", RegWr, RW); end
        cmpCount++; if (BusW !== 64'hDEAD_BEEF) begin errCount++; $display("FAIL sp_busw2: got %h want deadbeef", BusW); end
        cmpCount++; if (GrantId !== 2'd2) begin errCount++; $display("FAIL sp_grantid2: got %0d want 2", GrantId); end
        setReq(1, 5'd7, 64'h1111);
        ReqValid = 4'b0010;
        #1;
        cmpCount++; if (ReqReady !== 4'b0010) begin errCount++; $display("FAIL sp_ready1_wrap: got %b want 0010", ReqReady); end
        tick();
        cmpCount++; if (GrantId !== 2'd1 || RW !== 5'd7 || BusW !== 64'h1111) begin errCount++; $display("FAIL sp_write1: got id=%0d rw=%0d busw=%h want id=1 rw=7 busw=1111", GrantId, RW, BusW); end
        ReqValid = 4'b0000;
        #1;
        cmpCount++; if (ReqReady !== 4'b0000) begin errCount++; $display("FAIL sp_idle_ready: got %b want 0000", ReqReady); end
        tick();
        cmpCount++; if (RegWr !== 1'b0) begin errCount++; $display("FAIL sp_idle_regwr: got %b want 0", RegWr); end
        cmpCount++; if (RW !== 5'd7 || GrantId !== 2'd1 || BusW !== 64'h1111) begin errCount++; $display("FAIL sp_idle_hold: got rw=%0d id=%0d busw=%h want rw=7 id=1 busw=1111", RW, GrantId, BusW); end
    endtask

    task automatic test_zero_drop();
        do_reset();
        setReq(0, 5'd31, 64'h5555);
        ReqValid = 4'b0001;
        #1;
        cmpCount++; if (ReqReady !== 4'b0001) begin errCount++; $display("FAIL zr_ready: got %b want 0001", ReqReady); end
        tick();
        cmpCount++; if (RegWr !== 1'b0) begin errCount++; $display("FAIL zr_regwr: got %b want 0", RegWr); end
        cmpCount++; if (DropCount !== 16'd1) begin errCount++; $display("FAIL zr_count1: got %0d want 1", DropCount); end
        cmpCount++; if (GrantId !== 2'd0 || RW !== 5'd31) begin errCount++; $display("FAIL zr_regs: got id=%0d rw=%0d want id=0 rw=31", GrantId, RW); end
        repeat (65533) @(posedge Clk);
        #1;
        cmpCount++; if (DropCount !== 16'hFFFE) begin errCount++; $display("FAIL zr_count_fffe: got %h want fffe", DropCount); end
        for (int j = 0; j < 3; j++) begin
            tick();
            cmpCount++; if (DropCount !== 16'hFFFF) begin errCount++; $display("FAIL zr_sat[%0d]: got %h want ffff", j, DropCount); end
            cmpCount++; if (RegWr !== 1'b0) begin errCount++; $display("FAIL zr_sat_regwr[%0d]: got %b want 0", j, RegWr); end
        end
        setReq(0, 5'd3, 64'h3333);
        tick();
        cmpCount++; if (RegWr !== 1'b1 || RW !== 5'd3 || DropCount !== 16'hFFFF) begin errCount++; $display("FAIL zr_resume: got regwr=%b rw=%0d cnt=%h want regwr=1 rw=3 cnt=ffff", RegWr, RW, DropCount); end
    endtask

    task automatic test_hold();
        do_reset();
        setReq(2, 5'd6, 64'h2222);
        ReqValid = 4'b0100;
        tick();
        cmpCount++; if (GrantId !== 2'd2) begin errCount++; $display("FAIL hd_setup: got %0d want 2", GrantId); end
        setReq(0, 5'd8, 64'h8888);
        setReq(1, 5'd9, 64'h9999);
        ReqValid = 4'b0011;
        Hold = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            cmpCount++; if (ReqReady !== 4'b0000) begin errCount++; $display("FAIL hd_ready[%0d]: got %b want 0000", j, ReqReady); end
            tick();
            cmpCount++; if (RegWr !== 1'b0) begin errCount++; $display("FAIL hd_regwr[%0d]: got %b want 0", j, RegWr); end
            cmpCount++; if (RW !== 5'd6 || GrantId !== 2'd2) begin errCount++; $display("FAIL hd_hold[%0d]: got rw=%0d id=%0d want rw=6 id=2", j, RW, GrantId); end
        end
        Hold = 1'b0;
        #1;
        cmpCount++; if (ReqReady !== 4'b0001) begin errCount++; $display("FAIL hd_release_ready: got %b want 0001", ReqReady); end
        tick();
        cmpCount++; if (GrantId !== 2'd0 || RW !== 5'd8 || RegWr !== 1'b1) begin errCount++; $display("FAIL hd_first: got id=%0d rw=%0d regwr=%b want id=0 rw=8 regwr=1", GrantId, RW, RegWr); end
        ReqValid = 4'b0010;
        #1;
        cmpCount++; if (ReqReady !== 4'b0010) begin errCount++; $display("FAIL hd_second_ready: got %b want 0010", ReqReady); end
        tick();
        cmpCount++; if (GrantId !== 2'd1 || RW !== 5'd9) begin errCount++; $display("FAIL hd_second: got id=%0d rw=%0d want id=1 rw=9", GrantId, RW); end
        ReqValid = 4'b0000;
    endtask

    task automatic test_end_to_end();
        logic [NR-1:0] granted;
        do_reset();
        for (int i = 0; i < NR; i++) setReq(i, AW'(i + 1), 64'h0123_4567_89AB_CD00 + 64'(i * 17));
        ReqValid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            granted = ReqReady & ReqValid;
            cmpCount++; if (granted !== (4'b0001 << k)) begin errCount++; $display("FAIL e2e_grant[%0d]: got %b want %b", k, granted, 4'b0001 << k); end
            tick();
            ReqValid = ReqValid & ~granted;
        end
        setReq(0, 5'd9, 64'hAAAA);
        setReq(1, 5'd9, 64'hBBBB);
        ReqValid = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            #1;
            granted = ReqReady & ReqValid;
            tick();
            ReqValid = ReqValid & ~granted;
        end
        setReq(0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        ReqValid = 4'b0001;
        #1;
        granted = ReqReady & ReqValid;
        tick();
        ReqValid = ReqValid & ~granted;
        @(negedge Clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            cmpCount++; if (rf[i + 1] !== 64'h0123_4567_89AB_CD00 + 64'(i * 17)) begin errCount++; $display("FAIL e2e_x%0d: got %h want %h", i + 1, rf[i + 1], 64'h0123_4567_89AB_CD00 + 64'(i * 17)); end
        end
        cmpCount++; if (rf[9] !== 64'hBBBB) begin errCount++; $display("FAIL e2e_same_rw: got %h want bbbb", rf[9]); end
        cmpCount++; if (rf[31] !== 64'd0) begin errCount++; $display("FAIL e2e_x31: got %h want 0", rf[31]); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_sparse();
        test_zero_drop();
        test_hold();
        test_end_to_end();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end
endmodule
